// File: rtl/max_seq_pkg.sv
// Shared types and default sizing for the frame-maximum tracker.
package max_seq_pkg;
  localparam int DEF_WIDTH  = 3;
  localparam int DEF_MAXLEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/max_cmp.sv
// Unsigned strict greater-than comparator; purely combinational.
module max_cmp #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);
  assign gt = (a > b);
endmodule

// File: rtl/max_seq_ctrl.sv
// Tracks the largest operand of a frame and its first index; result is held
// in HOLD until the consumer takes it, and no operand is accepted meanwhile.
module max_seq_ctrl
  import max_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int MAXLEN = DEF_MAXLEN,
  localparam int IW    = $clog2(MAXLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IW-1:0]    out_idx,
  output logic             out_ovf,
  output logic             busy
);
  localparam logic [IW-1:0] CNT_MAX = IW'(MAXLEN - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             gt;

  max_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a  (in_data),
    .b  (max_q),
    .gt (gt)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          max_d   = in_data;
          idx_d   = '0;
          cnt_d   = IW'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // cnt is the index of the operand being accepted, pinned at the top
          if (gt) begin
            max_d = in_data;
            idx_d = cnt_q;
          end
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + IW'(1);
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      max_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_max_seq_ctrl.sv
// Directed bench for max_seq_ctrl with hand-computed expectations.
module tb_max_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_max;
  logic [3:0] out_idx;
  logic       out_ovf;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  max_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_max", 32'(out_max), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Frame 2,5,3,5: tie on 5 keeps the earlier index
    send(3'd2, 1'b0);
    chk("f1_busy", 32'(busy), 1);
    send(3'd5, 1'b0);
    send(3'd3, 1'b0);
    chk("f1_valid_early", 32'(out_valid), 0);
    send(3'd5, 1'b1);
    chk("f1_valid", 32'(out_valid), 1);
    chk("f1_max", 32'(out_max), 5);
    chk("f1_idx", 32'(out_idx), 1);
    chk("f1_ovf", 32'(out_ovf), 0);
    chk("f1_in_ready", 32'(in_ready), 0);
    take();
    chk("f1_valid_after", 32'(out_valid), 0);
    chk("f1_busy_after", 32'(busy), 0);
    chk("f1_ready_after", 32'(in_ready), 1);

    // 16 zeros then 6: saturation, overflow, compare at idx 15
    for (int i = 0; i < 16; i++) send(3'd0, 1'b0);
    chk("ovf_valid_early", 32'(out_valid), 0);
    send(3'd6, 1'b1);
    chk("ovf_valid", 32'(out_valid), 1);
    chk("ovf_max", 32'(out_max), 6);
    chk("ovf_idx", 32'(out_idx), 15);
    chk("ovf_flag", 32'(out_ovf), 1);
    take();

    // Single operand frame; overflow must clear
    send(3'd7, 1'b1);
    chk("one_valid", 32'(out_valid), 1);
    chk("one_max", 32'(out_max), 7);
    chk("one_idx", 32'(out_idx), 0);
    chk("one_busy", 32'(busy), 1);
    chk("one_ovf", 32'(out_ovf), 0);
    take();

    // Result held under backpressure while operands are offered
    send(3'd1, 1'b0);
    send(3'd3, 1'b1);
    in_valid = 1'b1; in_data = 3'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_max", 32'(out_max), 3);
      chk("hold_idx", 32'(out_idx), 1);
    end
    in_valid = 1'b0;
    take();
    chk("hold_release_valid", 32'(out_valid), 0);
    chk("hold_release_busy", 32'(busy), 0);
    chk("hold_release_max", 32'(out_max), 3);

    // Reset mid-frame discards partial result
    send(3'd1, 1'b0);
    send(3'd2, 1'b0);
    send(3'd3, 1'b0);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(in_ready), 0);
    chk("mid_rst_max", 32'(out_max), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_ready_back", 32'(in_ready), 1);
    chk("mid_rst_no_valid", 32'(out_valid), 0);
    send(3'd1, 1'b0);
    send(3'd4, 1'b1);
    chk("after_rst_valid", 32'(out_valid), 1);
    chk("after_rst_max", 32'(out_max), 4);
    chk("after_rst_idx", 32'(out_idx), 1);
    take();

    // Gaps in in_valid leave state untouched
    send(3'd3, 1'b0);
    tick();
    chk("gap_busy", 32'(busy), 1);
    chk("gap_max", 32'(out_max), 3);
    tick();
    chk("gap_valid", 32'(out_valid), 0);
    send(3'd6, 1'b1);
    chk("gap_out_valid", 32'(out_valid), 1);
    chk("gap_out_max", 32'(out_max), 6);
    chk("gap_out_idx", 32'(out_idx), 1);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/max_seq_ctrl.md
MAX_SEQ_CTRL -- requirements
Module: max_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH SHALL default to 3 and set the operand width.
REQ-003 Parameter MAXLEN SHALL default to 16 and set the frame-length limit, a power of two.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: operand offered.
REQ-007 Port in_data, input, WIDTH: unsigned operand.
REQ-008 Port in_last, input, 1: the offered operand ends the frame.
REQ-009 Port in_ready, output, 1: the block accepts an operand this cycle.
REQ-010 Port out_valid, output, 1: a frame result is presented.
REQ-011 Port out_ready, input, 1: the consumer takes the result.
REQ-012 Port out_max, output, WIDTH: largest operand in the frame.
REQ-013 Port out_idx, output, log2(MAXLEN): position of the first occurrence of out_max.
REQ-014 Port out_ovf, output, 1: the frame exceeded MAXLEN operands.
REQ-015 Port busy, output, 1: a frame is open or a result is pending.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-017 An operand SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-019 An accept in IDLE SHALL load max=in_data, idx=0 and cnt=1, clear ovf, and go to ACCUM, or to HOLD if in_last is 1.
REQ-020 An accept in ACCUM SHALL replace max and idx only when in_data > max (strictly greater), so ties keep the earliest index.
REQ-021 In ACCUM, idx SHALL take the value of cnt at the replacing accept.
REQ-022 In ACCUM, cnt SHALL increment on each accept and saturate at MAXLEN-1.
REQ-023 An accept when cnt is already MAXLEN-1 SHALL set ovf; that operand is still compared, using idx MAXLEN-1.
REQ-024 An accept with in_last=1 SHALL move the FSM to HOLD on the next edge.
REQ-025 out_valid SHALL be 1 exactly while in HOLD, so the result appears 1 cycle after the last accept.
REQ-026 out_max, out_idx and out_ovf SHALL be registered and stable throughout HOLD.
REQ-027 In HOLD, out_ready=1 SHALL return the FSM to IDLE on the next edge; out_valid is 0 in that next cycle.
REQ-028 While out_ready=0 in HOLD, the result SHALL be held and no operand is accepted.
REQ-029 in_valid=0 in ACCUM SHALL leave all state unchanged; gaps are allowed.
REQ-030 busy SHALL be 1 in ACCUM and HOLD, and 0 in IDLE.
REQ-031 Comparison SHALL be unsigned over WIDTH bits, with no sign extension.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force IDLE and set out_valid=0, busy=0, out_max=0, out_idx=0, out_ovf=0 and cnt=0.
REQ-033 in_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after deassertion.
REQ-034 Reset mid-frame or mid-HOLD SHALL discard the partial result, with no output handshake.

Structure
REQ-035 Package max_seq_pkg SHALL hold the state enum and the default WIDTH and MAXLEN constants.
REQ-036 The comparison SHALL be a combinational sub-module max_cmp (a > b, WIDTH-parameterised), instantiated once and shared across all accepts.
REQ-037 The block SHALL have a single clock domain, with no latches.

Verification
REQ-038 The bench SHALL cover: frame 2,5,3,5 (last on 4th) -> out_max=5, out_idx=1, out_ovf=0, out_valid 1 cycle after the last accept.
REQ-039 The bench SHALL cover: single operand 7 with in_last -> next cycle out_max=7, out_idx=0, busy=1.
REQ-040 The bench SHALL cover: 17 operands 0..0 then 6 last, MAXLEN=16 -> out_max=6, out_idx=15, out_ovf=1.
REQ-041 The bench SHALL cover: result pending with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0, outputs stable, then out_ready=1 -> IDLE next cycle.
REQ-042 The bench SHALL cover: rst_n pulsed low after 3 accepts -> immediate out_valid=0 and busy=0, then new frame 1,4 -> out_max=4, out_idx=1.
REQ-043 The bench SHALL cover: in_valid gaps between operands 3,_,_,6 -> out_max=6, out_idx=1.
